// File: rtl/iram_dp_ctrl_if.sv
// Bus-side command/response channel of the dual-port instruction RAM.
// master drives commands and accepts responses; slave is the controller.
interface iram_dp_ctrl_if;
  logic        iram_cmd_valid;
  logic        iram_cmd_ready;
  logic [31:0] iram_cmd_addr;
  logic        iram_cmd_we;
  logic [3:0]  iram_cmd_wem;
  logic [31:0] iram_cmd_wdata;
  logic        iram_rsp_valid;
  logic        iram_rsp_ready;
  logic [31:0] iram_rsp_rdata;
  logic        iram_rsp_error;

  modport master (
    output iram_cmd_valid, iram_cmd_addr, iram_cmd_we, iram_cmd_wem, iram_cmd_wdata,
    output iram_rsp_ready,
    input  iram_cmd_ready, iram_rsp_valid, iram_rsp_rdata, iram_rsp_error
  );

  modport slave (
    input  iram_cmd_valid, iram_cmd_addr, iram_cmd_we, iram_cmd_wem, iram_cmd_wdata,
    input  iram_rsp_ready,
    output iram_cmd_ready, iram_rsp_valid, iram_rsp_rdata, iram_rsp_error
  );
endinterface

// File: rtl/iram_dp_ctrl.sv
// Dual-port instruction RAM: port A is the core fetch port with reset hold-off,
// port B is a valid/ready bus port with window decode and a FWFT response FIFO.
module iram_dp_ctrl #(
  parameter int          DEPTH_WORDS    = 8192,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] RST_PC         = 32'h0000_0000,
  parameter int          RSP_FIFO_DEPTH = 2,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   pc_n_i,
  input  logic          iram_rd_i,
  output logic [31:0]   pc_o,
  output logic [31:0]   inst_o,
  output logic          fetch_err_o,
  output logic          fetch_hold_o,
  iram_dp_ctrl_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          PW        = $clog2(RSP_FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  function automatic logic in_win(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) &&
           (({1'b0, a} - {1'b0, BASE_ADDR}) < WIN_BYTES);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- reset synchroniser (fetch side) ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hold;
  logic                   hold_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign hold = ~sync_q[SYNC_STAGES-1];

  // ---------------- fetch port ----------------
  logic [31:0]   pc_q;
  logic [31:0]   ram_a_q;
  logic          inst_vld_q;
  logic          ferr_q;
  logic          a_win;
  logic          a_fetch;
  logic          a_en;
  logic [AW-1:0] a_idx;

  assign a_win   = in_win(pc_n_i);
  // The first cycle out of hold-off always loads pc_n_i so the core starts cleanly.
  assign a_fetch = ~hold & (iram_rd_i | hold_dly_q);
  assign a_en    = hold | (a_fetch & a_win);
  assign a_idx   = hold ? word_idx(RST_PC) : word_idx(pc_n_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RST_PC;
      inst_vld_q <= 1'b0;
      ferr_q     <= 1'b0;
      hold_dly_q <= 1'b1;
    end else begin
      hold_dly_q <= hold;
      if (hold) begin
        pc_q       <= RST_PC;
        inst_vld_q <= 1'b0;
        ferr_q     <= 1'b0;
      end else if (a_fetch) begin
        pc_q       <= pc_n_i;
        inst_vld_q <= a_win;
        ferr_q     <= ~a_win;
      end
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_vld_q ? ram_a_q : NOP;
  assign fetch_err_o  = ferr_q;
  assign fetch_hold_o = hold;

  // ---------------- bus command side ----------------
  logic          live_q;
  logic          hs;
  logic          b_win;
  logic          b_rd;
  logic          b_wr;
  logic [AW-1:0] b_idx;
  logic          pend_q;
  logic          pend_rd_q;
  logic          pend_err_q;
  logic [31:0]   ram_b_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic          push, pop;
  rsp_t          push_ent;
  rsp_t          fifo_q [RSP_FIFO_DEPTH];

  assign bus.iram_cmd_ready = live_q && ((count_q + CW'(pend_q)) < CW'(RSP_FIFO_DEPTH));
  assign hs    = bus.iram_cmd_valid & bus.iram_cmd_ready;
  assign b_win = in_win(bus.iram_cmd_addr);
  assign b_idx = word_idx(bus.iram_cmd_addr);
  assign b_rd  = hs & ~bus.iram_cmd_we & b_win;
  assign b_wr  = hs &  bus.iram_cmd_we & b_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_rd_q  <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      pend_q     <= hs;
      pend_rd_q  <= b_rd;
      pend_err_q <= hs & ~b_win;
    end
  end

  // Both ports share one block: NBA ordering gives read-first on collisions.
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (a_en) ram_a_q <= mem_q[a_idx];
    if (b_rd) ram_b_q <= mem_q[b_idx];
    if (b_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.iram_cmd_wem[i]) mem_q[b_idx][8*i +: 8] <= bus.iram_cmd_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- response FIFO ----------------
  assign push           = pend_q;
  assign push_ent.rdata = pend_rd_q ? ram_b_q : 32'h0;
  assign push_ent.error = pend_err_q;
  assign pop            = bus.iram_rsp_valid & bus.iram_rsp_ready;
  assign count_d        = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= push_ent;
  end

  assign bus.iram_rsp_valid = (count_q != '0);
  assign bus.iram_rsp_rdata = bus.iram_rsp_valid ? fifo_q[rptr_q].rdata : 32'h0;
  assign bus.iram_rsp_error = bus.iram_rsp_valid & fifo_q[rptr_q].error;

  a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(RSP_FIFO_DEPTH))));

endmodule

// File: tb/tb_iram_dp_ctrl.sv
// Randomised and directed checks of iram_dp_ctrl against a queue/array model.
module tb_iram_dp_ctrl;
  localparam int          D     = 64;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] RSTPC = 32'h0000_0104;
  localparam int          FD    = 2;
  localparam int          S     = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_s;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_n_i;
  logic        iram_rd_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        fetch_err_o;
  logic        fetch_hold_o;

  iram_dp_ctrl_if bus ();

  iram_dp_ctrl #(
    .DEPTH_WORDS(D), .BASE_ADDR(BASE), .RST_PC(RSTPC),
    .RSP_FIFO_DEPTH(FD), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_n_i(pc_n_i), .iram_rd_i(iram_rd_i),
    .pc_o(pc_o), .inst_o(inst_o), .fetch_err_o(fetch_err_o),
    .fetch_hold_o(fetch_hold_o), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm [D];
  bit          kn [D];
  logic [31:0] m_pc   = RSTPC;
  logic [31:0] m_inst = NOP;
  bit          m_kn   = 1'b1;
  bit          m_err  = 1'b0;
  int          m_rel  = 0;
  rsp_s        rspq [$];
  bit          pend   = 1'b0;
  rsp_s        pend_ent;

  function automatic bit m_win(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * D);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rel = 0; m_pc = RSTPC; m_inst = NOP; m_kn = 1'b1; m_err = 1'b0;
      rspq.delete(); pend = 1'b0;
    end else begin
      bit rdy;
      rdy = (rspq.size() + int'(pend)) < FD;
      // fetch side sees memory before this edge's bus write
      if (m_rel < S) begin
        m_pc = RSTPC; m_inst = NOP; m_kn = 1'b1; m_err = 1'b0;
      end else if (iram_rd_i || m_rel == S) begin
        m_pc = pc_n_i;
        if (m_win(pc_n_i)) begin
          m_inst = mm[m_idx(pc_n_i)]; m_kn = kn[m_idx(pc_n_i)]; m_err = 1'b0;
        end else begin
          m_inst = NOP; m_kn = 1'b1; m_err = 1'b1;
        end
      end
      if (rspq.size() != 0 && bus.iram_rsp_ready) void'(rspq.pop_front());
      if (pend) rspq.push_back(pend_ent);
      pend = bus.iram_cmd_valid && rdy;
      if (pend) begin
        if (!m_win(bus.iram_cmd_addr)) begin
          pend_ent = '{rdata: 32'h0, err: 1'b1};
        end else if (bus.iram_cmd_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.iram_cmd_wem[b])
              mm[m_idx(bus.iram_cmd_addr)][8*b +: 8] = bus.iram_cmd_wdata[8*b +: 8];
          if (bus.iram_cmd_wem == 4'hF) kn[m_idx(bus.iram_cmd_addr)] = 1'b1;
          pend_ent = '{rdata: 32'h0, err: 1'b0};
        end else begin
          pend_ent = '{rdata: mm[m_idx(bus.iram_cmd_addr)], err: 1'b0};
        end
      end
      if (m_rel <= S) m_rel++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("pc_o", pc_o, m_pc);
    if (m_kn) chk("inst_o", inst_o, m_inst);
    chk("fetch_err_o", 32'(fetch_err_o), 32'(m_err));
    chk("fetch_hold_o", 32'(fetch_hold_o), 32'(m_rel < S));
    chk("rsp_valid", 32'(bus.iram_rsp_valid), 32'(rspq.size() != 0));
    chk("rsp_rdata", bus.iram_rsp_rdata, (rspq.size() != 0) ? rspq[0].rdata : 32'h0);
    chk("rsp_error", 32'(bus.iram_rsp_error), (rspq.size() != 0) ? 32'(rspq[0].err) : 32'h0);
    if (!rst_n)         chk("cmd_ready_rst", 32'(bus.iram_cmd_ready), 32'h0);
    else if (m_rel >= S) chk("cmd_ready", 32'(bus.iram_cmd_ready), 32'((rspq.size() + int'(pend)) < FD));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_cmd(input logic we, input logic [31:0] a, input logic [3:0] wem,
                         input logic [31:0] wd);
    bit acc = 1'b0;
    bus.iram_cmd_valid = 1'b1; bus.iram_cmd_we = we; bus.iram_cmd_addr = a;
    bus.iram_cmd_wem = wem;    bus.iram_cmd_wdata = wd;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.iram_cmd_ready) begin acc = 1'b1; break; end
    end
    if (!acc) chk("cmd_accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    bus.iram_cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic e);
    bit got = 1'b0;
    d = 32'hx; e = 1'bx;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.iram_rsp_valid) begin
        d = bus.iram_rsp_rdata; e = bus.iram_rsp_error; got = 1'b1; break;
      end
    end
    if (!got) chk("rsp_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    pc_n_i = pc; iram_rd_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] rd_d;
  logic        rd_e;

  initial begin
    foreach (kn[i]) kn[i] = 1'b0;
    foreach (mm[i]) mm[i] = 32'h0;
    rst_n = 1'b0; pc_n_i = BASE + 32'h10; iram_rd_i = 1'b1;
    bus.iram_cmd_valid = 1'b0; bus.iram_cmd_addr = '0; bus.iram_cmd_we = 1'b0;
    bus.iram_cmd_wem = '0; bus.iram_cmd_wdata = '0; bus.iram_rsp_ready = 1'b1;
    step(3);
    @(negedge clk);
    chk("rst_pc", pc_o, RSTPC);
    chk("rst_inst", inst_o, NOP);
    chk("rst_hold", 32'(fetch_hold_o), 32'h1);
    chk("rst_ready", 32'(bus.iram_cmd_ready), 32'h0);

    // reset release: two held cycles, then pc follows pc_n_i
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk("rel_hold0", 32'(fetch_hold_o), 32'h1); chk("rel_pc0", pc_o, RSTPC);
    @(negedge clk); chk("rel_hold1", 32'(fetch_hold_o), 32'h1); chk("rel_inst1", inst_o, NOP);
    @(negedge clk); chk("rel_hold2", 32'(fetch_hold_o), 32'h0); chk("rel_pc2", pc_o, RSTPC);
    @(negedge clk); chk("rel_pc3", pc_o, BASE + 32'h10);
    step(1);

    for (int i = 0; i < D; i++) bus_cmd(1'b1, BASE + 32'(4 * i), 4'hF, $urandom);
    step(4);

    // write, fetch, partial write, read back
    bus_cmd(1'b1, BASE + 32'h8, 4'hF, 32'hDEADBEEF);
    get_rsp(rd_d, rd_e);
    chk("wr_rsp_data", rd_d, 32'h0); chk("wr_rsp_err", 32'(rd_e), 32'h0);
    fetch(BASE + 32'h8);
    chk("fetch_deadbeef", inst_o, 32'hDEADBEEF);
    step(1);
    bus_cmd(1'b1, BASE + 32'h8, 4'b0010, 32'h0000AA00);
    get_rsp(rd_d, rd_e);
    bus_cmd(1'b0, BASE + 32'h8, 4'h0, 32'h0);
    get_rsp(rd_d, rd_e);
    chk("bytelane_read", rd_d, 32'hDEADAAEF);
    bus_cmd(1'b1, BASE + 32'h0, 4'hF, 32'h12345678); get_rsp(rd_d, rd_e);
    bus_cmd(1'b1, BASE + 32'h4, 4'hF, 32'hCAFEF00D); get_rsp(rd_d, rd_e);
    bus_cmd(1'b1, BASE + 32'hC, 4'h0, 32'hFFFFFFFF); get_rsp(rd_d, rd_e);
    chk("wem0_rsp_err", 32'(rd_e), 32'h0);

    // backpressure: two accepted, third stalls until the first pop
    bus.iram_rsp_ready = 1'b0;
    bus.iram_cmd_valid = 1'b1; bus.iram_cmd_we = 1'b0; bus.iram_cmd_addr = BASE;
    @(negedge clk); chk("bp_rdy_a", 32'(bus.iram_cmd_ready), 32'h1);
    @(posedge clk); #1; bus.iram_cmd_addr = BASE + 32'h4;
    @(negedge clk); chk("bp_rdy_b", 32'(bus.iram_cmd_ready), 32'h1);
    @(posedge clk); #1; bus.iram_cmd_addr = BASE + 32'h8;
    @(negedge clk); chk("bp_rdy_c", 32'(bus.iram_cmd_ready), 32'h0);
    @(posedge clk); #1; bus.iram_rsp_ready = 1'b1;
    @(negedge clk); chk("bp_head_a", bus.iram_rsp_rdata, 32'h12345678);
    chk("bp_rdy_full", 32'(bus.iram_cmd_ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_rdy_after_pop", 32'(bus.iram_cmd_ready), 32'h1);
    chk("bp_head_b", bus.iram_rsp_rdata, 32'hCAFEF00D);
    @(posedge clk); #1; bus.iram_cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk); chk("bp_head_c", bus.iram_rsp_rdata, 32'hDEADAAEF);
    step(2);

    // out-of-window bus and fetch
    bus_cmd(1'b0, BASE + 32'(4 * D), 4'h0, 32'h0); get_rsp(rd_d, rd_e);
    chk("oow_err", 32'(rd_e), 32'h1); chk("oow_rdata", rd_d, 32'h0);
    bus_cmd(1'b1, BASE - 32'h4, 4'hF, 32'hBADBADBA); get_rsp(rd_d, rd_e);
    chk("oow_wr_err", 32'(rd_e), 32'h1);
    fetch(BASE + 32'(4 * D));
    chk("oow_fetch_inst", inst_o, NOP); chk("oow_fetch_err", 32'(fetch_err_o), 32'h1);
    step(1);

    // collision: fetch and bus write to word 4 in the same cycle
    bus_cmd(1'b1, BASE + 32'h10, 4'hF, 32'h22222222); get_rsp(rd_d, rd_e);
    pc_n_i = BASE + 32'h10; iram_rd_i = 1'b1;
    bus.iram_cmd_valid = 1'b1; bus.iram_cmd_we = 1'b1; bus.iram_cmd_addr = BASE + 32'h10;
    bus.iram_cmd_wem = 4'hF; bus.iram_cmd_wdata = 32'h11111111;
    @(negedge clk); chk("col_ready", 32'(bus.iram_cmd_ready), 32'h1);
    @(posedge clk); #1; bus.iram_cmd_valid = 1'b0;
    @(negedge clk); chk("col_old", inst_o, 32'h22222222);
    @(negedge clk); chk("col_new", inst_o, 32'h11111111);
    step(3);

    // reset with two responses queued
    bus.iram_rsp_ready = 1'b0;
    bus_cmd(1'b0, BASE, 4'h0, 32'h0);
    bus_cmd(1'b0, BASE + 32'h4, 4'h0, 32'h0);
    @(negedge clk); chk("mid_queued", 32'(bus.iram_rsp_valid), 32'h1);
    @(posedge clk); #1; rst_n = 1'b0; #1;
    chk("mid_rsp_valid", 32'(bus.iram_rsp_valid), 32'h0);
    step(2); rst_n = 1'b1; bus.iram_rsp_ready = 1'b1;
    step(5);
    @(negedge clk); chk("mid_no_stale", 32'(bus.iram_rsp_valid), 32'h0);
    @(posedge clk); #1;
    bus_cmd(1'b0, BASE + 32'h10, 4'h0, 32'h0); get_rsp(rd_d, rd_e);
    chk("mid_retained", rd_d, 32'h11111111);

    // randomised traffic on both ports
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        bus.iram_cmd_valid = 1'b0; rst_n = 1'b0;
        step(2); rst_n = 1'b1; step(4);
      end
      if ($urandom_range(0, 9) == 0)
        pc_n_i = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * D) + $urandom_range(0, 63)
                                             : BASE - 32'($urandom_range(1, 64));
      else
        pc_n_i = BASE + 32'($urandom_range(0, 4 * D - 1));
      iram_rd_i          = ($urandom_range(0, 3) != 0);
      bus.iram_cmd_valid = ($urandom_range(0, 9) < 6);
      bus.iram_cmd_we    = $urandom_range(0, 1) == 1;
      bus.iram_cmd_wem   = 4'($urandom);
      bus.iram_cmd_wdata = $urandom;
      bus.iram_cmd_addr  = ($urandom_range(0, 9) == 0) ? BASE + 32'(4 * D) + 32'(4 * $urandom_range(0, 7))
                                                       : BASE + 32'(4 * $urandom_range(0, D - 1));
      bus.iram_rsp_ready = ($urandom_range(0, 9) < 7);
      step(1);
    end
    bus.iram_cmd_valid = 1'b0; bus.iram_rsp_ready = 1'b1;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
